// File: rtl/battle_pkg.sv
// Shared types and constants for the battle controller.
package battle_pkg;

  typedef enum logic [2:0] {
    NO_BATTLE      = 3'd0,
    INIT_BOSS      = 3'd1,
    START_BATTLE   = 3'd2,
    USER_TURN      = 3'd3,
    SHOW_USER_MOVE = 3'd4,
    BOSS_TURN      = 3'd5,
    SHOW_BOSS_MOVE = 3'd6,
    BATTLE_OVER    = 3'd7
  } battle_state_t;

  // Damage per move index; element 0 is the least significant byte.
  localparam logic [7:0][7:0] MOVE_DMG = {8'd50, 8'd40, 8'd35, 8'd30,
                                          8'd25, 8'd20, 8'd15, 8'd10};

  // x^8 + x^6 + x^5 + x^4 + 1 as a Fibonacci tap mask over q[7:0].
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used to pick boss moves.
module lfsr8
  import battle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  // Shift left every cycle, feeding back the XOR of the tapped bits.
  always_ff @(posedge clk) begin
    if (reset) q <= LFSR_SEED;
    else       q <= {q[6:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/battle_fsm.sv
// Trainer-vs-boss battle sequencer: turn order, HP bookkeeping, display holds.
module battle_fsm
  import battle_pkg::*;
#(
  parameter int HP_W        = 8,
  parameter int USER_HP     = 100,
  parameter int BOSS_HP     = 120,
  parameter int NUM_MOVES   = 4,
  parameter int SHOW_CYCLES = 50_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         battle_bit,
  input  logic                         move_valid,
  input  logic [$clog2(NUM_MOVES)-1:0] move_sel,
  output logic [2:0]                   state,
  output logic [HP_W-1:0]              user_hp,
  output logic [HP_W-1:0]              boss_hp,
  output logic [$clog2(NUM_MOVES)-1:0] shown_move,
  output logic                         shown_is_boss,
  output logic                         battle_done,
  output logic                         user_won
);

  localparam int SEL_W = $clog2(NUM_MOVES);
  localparam int TMR_W = $clog2(SHOW_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SHOW_CYCLES - 1);

  battle_state_t    state_q, state_next;
  logic [TMR_W-1:0] timer_q;
  logic             hold_done;
  logic [7:0]       lfsr_q;
  logic [SEL_W-1:0] boss_move;
  logic [7-SEL_W:0] unused_lfsr;

  // Damage lookup for a move index of the configured width.
  function automatic logic [7:0] dmg_of(input logic [SEL_W-1:0] idx);
    logic [2:0] i3;
    i3 = 3'(idx);
    return MOVE_DMG[i3];
  endfunction

  // Subtract damage from HP, clamping at zero instead of wrapping.
  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                              input logic [7:0]      dmg);
    logic [HP_W+7:0] hp_w;
    logic [HP_W+7:0] dmg_w;
    logic [HP_W+7:0] diff;
    hp_w  = {8'd0, hp};
    dmg_w = {{HP_W{1'b0}}, dmg};
    diff  = hp_w - dmg_w;
    if (dmg_w >= hp_w) return '0;
    return diff[HP_W-1:0];
  endfunction

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign boss_move   = lfsr_q[SEL_W-1:0];
  assign unused_lfsr = lfsr_q[7:SEL_W];
  assign hold_done   = (timer_q == TMR_LAST);
  assign state       = state_q;

  // Next-state decode; a dropped battle_bit aborts any in-progress battle.
  always_comb begin
    state_next = state_q;
    case (state_q)
      NO_BATTLE:      if (battle_bit) state_next = INIT_BOSS;
      INIT_BOSS:      state_next = START_BATTLE;
      START_BATTLE:   if (hold_done) state_next = USER_TURN;
      USER_TURN:      if (move_valid) state_next = SHOW_USER_MOVE;
      SHOW_USER_MOVE: if (hold_done)
                        state_next = (boss_hp == '0) ? BATTLE_OVER : BOSS_TURN;
      BOSS_TURN:      state_next = SHOW_BOSS_MOVE;
      SHOW_BOSS_MOVE: if (hold_done)
                        state_next = (user_hp == '0) ? BATTLE_OVER : USER_TURN;
      BATTLE_OVER:    if (!battle_bit) state_next = NO_BATTLE;
      default:        state_next = NO_BATTLE;
    endcase
    if (!battle_bit && state_q != NO_BATTLE && state_q != BATTLE_OVER)
      state_next = NO_BATTLE;
  end

  // State, display timer and HP/move datapath; updates keyed on the taken transition
  // so an abort on the same cycle suppresses them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= NO_BATTLE;
      timer_q       <= '0;
      user_hp       <= '0;
      boss_hp       <= '0;
      shown_move    <= '0;
      shown_is_boss <= 1'b0;
      battle_done   <= 1'b0;
      user_won      <= 1'b0;
    end else begin
      state_q     <= state_next;
      battle_done <= (state_next == BATTLE_OVER);
      if (state_next != state_q) timer_q <= '0;
      else if (!hold_done)       timer_q <= timer_q + TMR_W'(1);

      if (state_q == INIT_BOSS) begin
        user_hp  <= HP_W'(USER_HP);
        boss_hp  <= HP_W'(BOSS_HP);
        user_won <= 1'b0;
      end
      if (state_q == USER_TURN && state_next == SHOW_USER_MOVE) begin
        shown_move    <= move_sel;
        shown_is_boss <= 1'b0;
        boss_hp       <= sat_sub(boss_hp, dmg_of(move_sel));
      end
      if (state_q == BOSS_TURN && state_next == SHOW_BOSS_MOVE) begin
        shown_move    <= boss_move;
        shown_is_boss <= 1'b1;
        user_hp       <= sat_sub(user_hp, dmg_of(boss_move));
      end
      if (state_q == SHOW_USER_MOVE && state_next == BATTLE_OVER) user_won <= 1'b1;
      if (state_q == SHOW_BOSS_MOVE && state_next == BATTLE_OVER) user_won <= 1'b0;
    end
  end

endmodule

// File: tb/tb_battle_fsm.sv
// Directed bench for battle_fsm with SHOW_CYCLES=4: entry, turns, KO, loss, aborts, reset.
module tb_battle_fsm;
  import battle_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       bb0 = 1'b0, mv0 = 1'b0;
  logic [1:0] sel0 = '0;
  logic [2:0] st0;
  logic [7:0] uhp0, bhp0;
  logic [1:0] smv0;
  logic       sboss0, done0, won0;

  logic       bb1 = 1'b0, mv1 = 1'b0;
  logic [1:0] sel1 = '0;
  logic [2:0] st1;
  logic [7:0] uhp1, bhp1;
  logic [1:0] smv1;
  logic       sboss1, done1, won1;

  int n_vec  = 0;
  int n_fail = 0;

  logic [7:0] lfsr_m;
  int         m_uhp  = 100;
  int         m_move = 0;
  int         m_bhp  = 95;

  localparam int DMG [8] = '{10, 15, 20, 25, 30, 35, 40, 50};

  battle_fsm #(.SHOW_CYCLES(4)) d0 (
    .clk(clk), .reset(reset), .battle_bit(bb0), .move_valid(mv0), .move_sel(sel0),
    .state(st0), .user_hp(uhp0), .boss_hp(bhp0), .shown_move(smv0),
    .shown_is_boss(sboss0), .battle_done(done0), .user_won(won0)
  );

  battle_fsm #(.SHOW_CYCLES(4), .USER_HP(10)) d1 (
    .clk(clk), .reset(reset), .battle_bit(bb1), .move_valid(mv1), .move_sel(sel1),
    .state(st1), .user_hp(uhp1), .boss_hp(bhp1), .shown_move(smv1),
    .shown_is_boss(sboss1), .battle_done(done1), .user_won(won1)
  );

  always #5 clk = ~clk;

  // Reference LFSR written out from the polynomial x^8+x^6+x^5+x^4+1.
  always @(posedge clk) begin
    if (reset) lfsr_m <= 8'hA5;
    else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  typedef struct {
    logic          bb;
    logic          mv;
    logic [1:0]    sel;
    int            n;
    battle_state_t st;
    int            uhp;
    int            bhp;
    int            smv;
    logic          sboss;
    logic          done;
    logic          won;
    logic          mdl;
  } vec_t;

  vec_t tbl [12];

  function automatic int sat(input int hp, input int d);
    return (d >= hp) ? 0 : hp - d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic boss_model();
    m_move = int'(lfsr_m[1:0]);
    m_uhp  = sat(m_uhp, DMG[m_move]);
  endtask

  // One full user turn with move 3 from USER_TURN; ends at USER_TURN or BATTLE_OVER.
  task automatic user_turn();
    m_bhp = sat(m_bhp, 25);
    mv0 = 1'b1; sel0 = 2'd3;
    step();
    mv0 = 1'b0;
    chk("turn_show_user_state", st0, SHOW_USER_MOVE);
    chk("turn_boss_hp", bhp0, m_bhp);
    chk("turn_shown_move", smv0, 3);
    chk("turn_shown_is_boss", sboss0, 0);
    repeat (4) step();
    if (m_bhp == 0) begin
      chk("ko_state", st0, BATTLE_OVER);
      chk("ko_done", done0, 1);
      chk("ko_won", won0, 1);
    end else begin
      chk("turn_boss_state", st0, BOSS_TURN);
      boss_model();
      step();
      chk("turn_show_boss_state", st0, SHOW_BOSS_MOVE);
      chk("turn_user_hp", uhp0, m_uhp);
      chk("turn_boss_move", smv0, m_move);
      chk("turn_boss_flag", sboss0, 1);
      repeat (4) step();
      chk("turn_back_user", st0, USER_TURN);
    end
  endtask

  initial begin
    // bb mv sel n state uhp bhp smv sboss done won mdl
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 1, INIT_BOSS,      0,   0,   0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 1, START_BATTLE,   100, 120, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 2'd0, 3, START_BATTLE,   100, 120, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 2'd0, 1, USER_TURN,      100, 120, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 2'd0, 2, USER_TURN,      100, 120, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 2'd3, 1, SHOW_USER_MOVE, 100, 95,  3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 2'd0, 3, SHOW_USER_MOVE, 100, 95,  3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 2'd0, 1, BOSS_TURN,      100, 95,  3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 2'd0, 1, SHOW_BOSS_MOVE, 0,   95,  0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 2'd3, 1, SHOW_BOSS_MOVE, 0,   95,  0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 2'd0, 2, SHOW_BOSS_MOVE, 0,   95,  0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 2'd0, 1, USER_TURN,      0,   95,  0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state
    step(); step();
    chk("rst_state", st0, NO_BATTLE);
    chk("rst_user_hp", uhp0, 0);
    chk("rst_boss_hp", bhp0, 0);
    chk("rst_shown_move", smv0, 0);
    chk("rst_shown_is_boss", sboss0, 0);
    chk("rst_done", done0, 0);
    chk("rst_won", won0, 0);
    reset = 1'b0;

    // Entry and first turn from the table (row 9 pulses move_valid in SHOW_BOSS_MOVE)
    for (int i = 0; i < 12; i++) begin
      bb0 = tbl[i].bb; mv0 = tbl[i].mv; sel0 = tbl[i].sel;
      step();
      mv0 = 1'b0;
      repeat (tbl[i].n - 1) step();
      chk($sformatf("row%0d_state", i), st0, tbl[i].st);
      chk($sformatf("row%0d_user_hp", i), uhp0, tbl[i].mdl ? m_uhp : tbl[i].uhp);
      chk($sformatf("row%0d_boss_hp", i), bhp0, tbl[i].bhp);
      chk($sformatf("row%0d_shown_move", i), smv0, tbl[i].mdl ? m_move : tbl[i].smv);
      chk($sformatf("row%0d_shown_is_boss", i), sboss0, tbl[i].sboss);
      chk($sformatf("row%0d_done", i), done0, tbl[i].done);
      chk($sformatf("row%0d_won", i), won0, tbl[i].won);
      if (tbl[i].st == BOSS_TURN) boss_model();
    end

    // Turns 2..5: boss HP 70, 45, 20, then saturates to 0 and the user wins
    for (int t = 0; t < 4; t++) user_turn();
    step();
    chk("over_hold", st0, BATTLE_OVER);
    bb0 = 1'b0;
    step();
    chk("over_exit_state", st0, NO_BATTLE);
    chk("over_exit_done", done0, 0);

    // Abort during SHOW_USER_MOVE
    bb0 = 1'b1;
    repeat (6) step();
    chk("ab1_user_turn", st0, USER_TURN);
    chk("ab1_reload_uhp", uhp0, 100);
    chk("ab1_reload_bhp", bhp0, 120);
    mv0 = 1'b1; sel0 = 2'd1;
    step();
    mv0 = 1'b0;
    chk("ab1_show", st0, SHOW_USER_MOVE);
    step();
    bb0 = 1'b0;
    step();
    chk("ab1_state", st0, NO_BATTLE);
    chk("ab1_boss_hp", bhp0, 105);
    chk("ab1_user_hp", uhp0, 100);

    // Abort together with move_valid in USER_TURN: abort wins, HP unchanged
    bb0 = 1'b1;
    repeat (6) step();
    chk("ab2_user_turn", st0, USER_TURN);
    bb0 = 1'b0; mv0 = 1'b1; sel0 = 2'd2;
    step();
    mv0 = 1'b0;
    chk("ab2_state", st0, NO_BATTLE);
    chk("ab2_boss_hp", bhp0, 120);
    chk("ab2_user_hp", uhp0, 100);
    chk("ab2_shown_move", smv0, 1);

    // User loss on the second instance (USER_HP=10)
    bb1 = 1'b1;
    repeat (6) step();
    chk("loss_user_turn", st1, USER_TURN);
    chk("loss_start_uhp", uhp1, 10);
    mv1 = 1'b1; sel1 = 2'd0;
    step();
    mv1 = 1'b0;
    chk("loss_boss_hp", bhp1, 110);
    repeat (4) step();
    chk("loss_boss_turn", st1, BOSS_TURN);
    step();
    chk("loss_show_boss", st1, SHOW_BOSS_MOVE);
    chk("loss_user_hp", uhp1, 0);
    repeat (4) step();
    chk("loss_state", st1, BATTLE_OVER);
    chk("loss_done", done1, 1);
    chk("loss_won", won1, 0);

    // Reset mid-battle
    bb0 = 1'b1;
    repeat (6) step();
    mv0 = 1'b1; sel0 = 2'd2;
    step();
    mv0 = 1'b0;
    chk("mid_pre_boss_hp", bhp0, 100);
    reset = 1'b1;
    step();
    chk("mid_rst_state", st0, NO_BATTLE);
    chk("mid_rst_uhp", uhp0, 0);
    chk("mid_rst_bhp", bhp0, 0);
    chk("mid_rst_smv", smv0, 0);
    chk("mid_rst_sboss", sboss0, 0);
    chk("mid_rst_done", done0, 0);
    chk("mid_rst_won", won0, 0);
    chk("mid_rst_d1_done", done1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/battle_fsm.md
# battle_fsm

Parametrised battle controller for the overworld/battle game. It sequences one trainer-vs-boss battle from entry through alternating turns to a win or loss. It tracks both HP values with saturating damage, picks boss moves from a free-running LFSR, and holds each move-display phase for a programmable number of cycles so the renderer can draw it. It sits between the overworld logic (which raises `battle_bit`) and the battle sprite/text renderer (which consumes its state and HP outputs).

## Interface
- `HP_W`, default 8: width of HP registers and outputs.
- `USER_HP`, default 100: user HP loaded at battle start (must fit `HP_W`).
- `BOSS_HP`, default 120: boss HP loaded at battle start (must fit `HP_W`).
- `NUM_MOVES`, default 4: moves per side; must be a power of two, 2..8.
- `SHOW_CYCLES`, default 50_000_000: cycles each display phase is held (≥1).

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high reset.
- `battle_bit` in 1: level; 1 = battle requested/active.
- `move_valid` in 1: one-cycle pulse, user has chosen a move.
- `move_sel` in `$clog2(NUM_MOVES)`: user move index, sampled with `move_valid`.
- `state` out 3: current `battle_state_t` encoding.
- `user_hp` out `HP_W`: current user HP.
- `boss_hp` out `HP_W`: current boss HP.
- `shown_move` out `$clog2(NUM_MOVES)`: move index being displayed.
- `shown_is_boss` out 1: 1 = displayed move is the boss's.
- `battle_done` out 1: high only in BATTLE_OVER.
- `user_won` out 1: valid while `battle_done`; 1 = boss HP reached 0.

## Operation
- States, 3 bits: NO_BATTLE, INIT_BOSS, START_BATTLE, USER_TURN, SHOW_USER_MOVE, BOSS_TURN, SHOW_BOSS_MOVE, BATTLE_OVER.
- NO_BATTLE: if `battle_bit`=1, go to INIT_BOSS.
- INIT_BOSS: one cycle. Load `user_hp`=USER_HP and `boss_hp`=BOSS_HP, clear `user_won`, then go to START_BATTLE.
- START_BATTLE: hold SHOW_CYCLES cycles (intro screen), then go to USER_TURN.
- USER_TURN: wait for `move_valid`. On the pulse:
  - latch `move_sel` into `shown_move` and clear `shown_is_boss`;
  - `boss_hp` ← sat(`boss_hp` − MOVE_DMG[`move_sel`]);
  - go to SHOW_USER_MOVE.
- SHOW_USER_MOVE: hold SHOW_CYCLES cycles. Then:
  - if `boss_hp`=0, go to BATTLE_OVER with `user_won`=1;
  - otherwise go to BOSS_TURN.
- BOSS_TURN: one cycle. Boss move m = LFSR[`$clog2(NUM_MOVES)`−1:0].
  - set `shown_move`=m and `shown_is_boss`=1;
  - `user_hp` ← sat(`user_hp` − MOVE_DMG[m]);
  - go to SHOW_BOSS_MOVE.
- SHOW_BOSS_MOVE: hold SHOW_CYCLES cycles. Then:
  - if `user_hp`=0, go to BATTLE_OVER with `user_won`=0;
  - otherwise go to USER_TURN.
- BATTLE_OVER: `battle_done`=1. Stay until `battle_bit`=0, then go to NO_BATTLE.
- Abort: `battle_bit`=0 in any state other than NO_BATTLE and BATTLE_OVER forces NO_BATTLE next cycle. HP values are left unchanged until the next INIT_BOSS.
- `move_valid` is ignored outside USER_TURN.
- Saturating subtract: if damage ≥ HP, result is 0. HP never wraps.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset. It advances every cycle in all states, so it is never all-zero.

## Timing
- Reset values:
  - `state`=NO_BATTLE;
  - `user_hp`=`boss_hp`=0;
  - `shown_move`=0, `shown_is_boss`=0;
  - `battle_done`=0, `user_won`=0.
- All outputs are registered.
- HP updates and `shown_*` are visible the cycle the state becomes SHOW_*.
- Display timer: counter width `$clog2(SHOW_CYCLES+1)`, cleared on every state change. A SHOW or START state lasts exactly SHOW_CYCLES cycles.
- Latency from `battle_bit` rising in NO_BATTLE to USER_TURN: 2 + SHOW_CYCLES cycles.
- Latency from `move_valid` to the next USER_TURN with no KO: 1 + SHOW_CYCLES + 1 + SHOW_CYCLES cycles.
- `battle_bit` falling on the same cycle as a `move_valid` in USER_TURN: abort wins and HP is unchanged.
- Reset mid-battle: the next cycle is NO_BATTLE with all outputs at their reset values.

## Structure
- Package `battle_pkg`:
  - `battle_state_t` enum (the 8 states above);
  - `MOVE_DMG` array of 8 bytes {10,15,20,25,30,35,40,50};
  - LFSR seed and tap constants.
- Sub-module `lfsr8`: clk, reset, 8-bit `q`. Free-running.
- Timer and HP datapath live inline in `battle_fsm`.

## Test plan
All scenarios use SHOW_CYCLES=4 and defaults otherwise.
- Reset, then `battle_bit`=1 → INIT_BOSS at +1, START_BATTLE at +2, USER_TURN at +6; HP reads 100/120.
- Move 3 in USER_TURN → `boss_hp`=95 and `shown_move`=3, `shown_is_boss`=0 next cycle; 4 cycles later BOSS_TURN; `user_hp` drops by MOVE_DMG[LFSR[1:0]] and matches the reference-model LFSR.
- Repeat move 3 → boss KO on the 5th hit; `boss_hp`=0 (saturated from 20, not wrapped), BATTLE_OVER, `battle_done`=1, `user_won`=1. Dropping `battle_bit` → NO_BATTLE.
- Force user loss with USER_HP=10 → `user_hp`=0 after the first boss hit, BATTLE_OVER, `user_won`=0.
- `battle_bit`→0 during SHOW_USER_MOVE and again during USER_TURN together with `move_valid` → NO_BATTLE next cycle; HP unchanged in the second case.
- `move_valid` pulsed during SHOW_BOSS_MOVE → ignored, HP unchanged. Reset asserted mid-battle → all outputs at reset values next cycle.
